// File: rtl/mm_pkg.sv
// Shared definitions for the Montgomery multiplier and its arbiter.
// Holds the field width, the arbiter state type and the field prime.
package mm_pkg;

    localparam int MM_WIDTH = 255;

    // p = 2^255 - 19
    localparam logic [MM_WIDTH-1:0] MM_PRIME = {MM_WIDTH{1'b1}} - MM_WIDTH'(18);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Scans upward from last_grant+1 with wrap-around; returns a one-hot winner.
module rr_picker #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic [N_REQ-1:0]         winner,
    output logic                     valid
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = IW'((int'(last_grant) + i) % N_REQ);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/montgomery_arbiter.sv
// Round-robin arbiter sharing one Montgomery multiplier among N_REQ requesters.
// One operation in flight; operands are latched at grant and held until done.
module montgomery_arbiter
    import mm_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = MM_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*WIDTH-1:0] i_a,
    input  logic [N_REQ*WIDTH-1:0] i_b,
    output logic [N_REQ-1:0]       o_gnt,
    output logic [N_REQ-1:0]       o_done,
    output logic [WIDTH-1:0]       o_result,
    output logic                   o_busy,
    output logic                   o_mm_start,
    output logic [WIDTH-1:0]       o_mm_a,
    output logic [WIDTH-1:0]       o_mm_b,
    input  logic [WIDTH-1:0]       i_mm_result,
    input  logic                   i_mm_finished
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t     state, state_next;
    logic [IW-1:0]  last_grant, owner, win_idx;
    logic [N_REQ-1:0] winner;
    logic           valid, grant_fire, finish_fire;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req       (i_req),
        .last_grant(last_grant),
        .winner    (winner),
        .valid     (valid)
    );

    always_comb begin
        win_idx = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (winner[j]) win_idx = IW'(j);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (grant_fire)  state_next = S_BUSY;
            S_BUSY:  if (finish_fire) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // A finish coinciding with our own start pulse cannot belong to this operation.
    always_comb begin
        grant_fire  = (state == S_IDLE) && valid;
        finish_fire = (state == S_BUSY) && i_mm_finished && !o_mm_start;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_gnt      <= '0;
            o_done     <= '0;
            o_result   <= '0;
            o_busy     <= 1'b0;
            o_mm_start <= 1'b0;
            o_mm_a     <= '0;
            o_mm_b     <= '0;
            owner      <= '0;
            last_grant <= IW'(N_REQ - 1);
        end else begin
            o_gnt      <= grant_fire ? winner : '0;
            o_mm_start <= grant_fire;
            o_done     <= '0;
            o_busy     <= (state_next == S_BUSY);
            if (grant_fire) begin
                o_mm_a <= i_a[win_idx*WIDTH +: WIDTH];
                o_mm_b <= i_b[win_idx*WIDTH +: WIDTH];
                owner  <= win_idx;
            end
            // Pointer moves on completion only, so an aborted grant leaves fairness untouched.
            if (finish_fire) begin
                o_result      <= i_mm_result;
                o_done[owner] <= 1'b1;
                last_grant    <= owner;
            end
        end
    end

endmodule

// File: tb/tb_montgomery_arbiter.sv
// Self-checking bench for montgomery_arbiter with a stub multiplier returning a+b.
// A transaction-level model predicts grant order, latencies and results.
module tb_montgomery_arbiter;

    localparam int N = 4;
    localparam int W = 255;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_drv;
    logic [N*W-1:0] a_flat, b_flat;
    logic [N-1:0]   gnt, done;
    logic [W-1:0]   result, mm_a, mm_b, mm_res;
    logic           busy, mm_start, mm_fin;

    logic [W-1:0]   op_a[N];
    logic [W-1:0]   op_b[N];

    int lat;
    int cnt;
    logic spur;

    int checks = 0;
    int failures = 0;

    int           last_m;
    logic [W-1:0] last_res;
    bit           outstanding;
    int           owner_m, gcyc, olat;
    logic [W-1:0] ea, eb;
    int           grants_q[$];

    always #5 clk = ~clk;

    always_comb begin
        a_flat = '0;
        b_flat = '0;
        for (int k = 0; k < N; k++) begin
            a_flat[k*W +: W] = op_a[k];
            b_flat[k*W +: W] = op_b[k];
        end
    end

    montgomery_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req_drv),
        .i_a          (a_flat),
        .i_b          (b_flat),
        .o_gnt        (gnt),
        .o_done       (done),
        .o_result     (result),
        .o_busy       (busy),
        .o_mm_start   (mm_start),
        .o_mm_a       (mm_a),
        .o_mm_b       (mm_b),
        .i_mm_result  (mm_res),
        .i_mm_finished(mm_fin)
    );

    function automatic logic [W-1:0] rand_op();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r[W-1:0];
    endfunction

    // Stub multiplier: finishes lat cycles after the start pulse; spur injects a bogus finish.
    always @(posedge clk) begin
        if (rst) begin
            cnt    <= 0;
            mm_fin <= 1'b0;
            mm_res <= '0;
        end else begin
            mm_fin <= spur;
            if (spur) mm_res <= rand_op();
            if (mm_start) begin
                cnt <= lat - 1;
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    mm_fin <= 1'b1;
                    mm_res <= mm_a + mm_b;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] p, input int last);
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (last + i) % N;
            if (p[k]) return k;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"},   256'(gnt), 256'(0));
        check({tag, "_done"},  256'(done), 256'(0));
        check({tag, "_busy"},  256'(busy), 256'(0));
        check({tag, "_start"}, 256'(mm_start), 256'(0));
        check({tag, "_mm_a"},  256'(mm_a), 256'(0));
        check({tag, "_mm_b"},  256'(mm_b), 256'(0));
        check({tag, "_res"},   256'(result), 256'(0));
    endtask

    task automatic model_reset();
        last_m      = N - 1;
        last_res    = '0;
        outstanding = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        req_drv = '0;
        spur    = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        rst = 1'b0;
        model_reset();
        lat = $urandom_range(2, 9);
    endtask

    // Cycle loop: grant expected the cycle after an idle cycle with pending requests,
    // done expected lat+1 cycles after the grant, results are a+b of the latched operands.
    task automatic run(input int n_ops, input bit hold, input bit raise, input int spur_mode);
        int issued, completed, ngr, w;
        bit prev_idle, fire, dfire, ok;
        logic [N-1:0] prev_pend, eg, ed;
        issued    = $countones(req_drv);
        completed = 0;
        ngr       = 0;
        ok        = 1'b0;
        w         = 0;
        grants_q.delete();
        prev_idle = !outstanding;
        prev_pend = req_drv;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            step();
            fire = prev_idle && (prev_pend != '0);
            eg = '0;
            if (fire) begin
                w = rr_pick(prev_pend, last_m);
                eg[w] = 1'b1;
            end
            check("gnt", 256'(gnt), 256'(eg));
            check("mm_start", 256'(mm_start), 256'(fire));
            if (fire) begin
                outstanding = 1'b1;
                owner_m = w;
                ea = op_a[w];
                eb = op_b[w];
                olat = lat;
                gcyc = cyc;
                grants_q.push_back(w);
                ngr++;
                if (!hold) req_drv[w] = 1'b0;
                op_a[w] = rand_op();
                op_b[w] = rand_op();
            end
            dfire = outstanding && !fire && (cyc == gcyc + olat + 1);
            check("busy", 256'(busy), 256'(fire || (outstanding && !dfire)));
            if (outstanding) begin
                check("mm_a_hold", 256'(mm_a), 256'(ea));
                check("mm_b_hold", 256'(mm_b), 256'(eb));
            end
            if (dfire) begin
                ed = '0;
                ed[owner_m] = 1'b1;
                check("done", 256'(done), 256'(ed));
                last_res = ea + eb;
                check("result", 256'(result), 256'(last_res));
                last_m = owner_m;
                outstanding = 1'b0;
                completed++;
                lat = $urandom_range(2, 9);
            end else begin
                check("done_quiet", 256'(done), 256'(0));
                check("result_hold", 256'(result), 256'(last_res));
            end
            spur = !outstanding && (spur_mode == 2 || (spur_mode == 1 && $urandom_range(0, 3) == 0));
            if (raise) begin
                for (int k = 0; k < N; k++) begin
                    if (issued < n_ops && !req_drv[k] && !(outstanding && owner_m == k)
                        && $urandom_range(0, 2) == 0) begin
                        op_a[k] = rand_op();
                        op_b[k] = rand_op();
                        req_drv[k] = 1'b1;
                        issued++;
                    end
                end
            end
            if (hold && ngr >= n_ops) req_drv = '0;
            prev_idle = !outstanding;
            prev_pend = req_drv;
            if (hold ? (ngr >= n_ops && !outstanding) : (completed >= n_ops)) begin
                ok = 1'b1;
                break;
            end
        end
        spur = 1'b0;
        check("run_complete", 256'(ok), 256'(1));
    endtask

    initial begin
        bit found;
        req_drv = '0;
        spur    = 1'b0;
        lat     = 5;
        for (int k = 0; k < N; k++) begin
            op_a[k] = '0;
            op_b[k] = '0;
        end
        model_reset();

        // Single requester, latency 5: a=3, b=361 -> 364 at t+7
        do_reset();
        lat = 5;
        op_a[2] = W'(3);
        op_b[2] = W'(361);
        req_drv = 4'b0100;
        run(1, 1'b0, 1'b0, 0);
        check("s1_result", 256'(result), 256'(364));

        // All four from reset, a=k, b=10k
        do_reset();
        for (int k = 0; k < N; k++) begin
            op_a[k] = W'(k);
            op_b[k] = W'(10 * k);
        end
        req_drv = 4'b1111;
        run(4, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++)
            check("s2_order", 256'(i < grants_q.size() ? grants_q[i] : -1), 256'(i));
        check("s2_last_result", 256'(result), 256'(33));

        // Fairness: 1 and 3 held high
        do_reset();
        op_a[1] = rand_op(); op_b[1] = rand_op();
        op_a[3] = rand_op(); op_b[3] = rand_op();
        req_drv = 4'b1010;
        run(6, 1'b1, 1'b0, 0);
        for (int i = 0; i < 6; i++)
            check("fair_order", 256'(i < grants_q.size() ? grants_q[i] : -1), 256'((i % 2 == 0) ? 1 : 3));

        // Spurious finish in idle, then finishes forced into every start cycle
        do_reset();
        spur = 1'b1;
        step();
        spur = 1'b0;
        step();
        check("spur_idle_done", 256'(done), 256'(0));
        check("spur_idle_busy", 256'(busy), 256'(0));
        check("spur_idle_res", 256'(result), 256'(0));
        run(6, 1'b0, 1'b1, 2);

        // Random traffic with occasional spurious finishes
        do_reset();
        run(30, 1'b0, 1'b1, 1);

        // Reset two cycles after a grant to requester 1
        do_reset();
        lat = 10;
        op_a[1] = rand_op();
        op_b[1] = rand_op();
        req_drv = 4'b0010;
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            step();
            if (gnt != '0) found = 1'b1;
        end
        check("abort_gnt_seen", 256'(found), 256'(1));
        check("abort_gnt", 256'(gnt), 256'(4'b0010));
        req_drv = '0;
        step();
        step();
        rst = 1'b1;
        step();
        check_idle_outputs("abort");
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            check("abort_no_done", 256'(done), 256'(0));
            check("abort_no_busy", 256'(busy), 256'(0));
        end
        model_reset();
        op_a[0] = rand_op(); op_b[0] = rand_op();
        op_a[2] = rand_op(); op_b[2] = rand_op();
        req_drv = 4'b0101;
        run(2, 1'b0, 1'b0, 0);
        for (int i = 0; i < 2; i++)
            check("abort_order", 256'(i < grants_q.size() ? grants_q[i] : -1), 256'(2 * i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
